// File: rtl/rand_dispenser.sv
// rand_dispenser: shared XorShift128+ generator behind a round-robin arbiter.
// Grants at most one requester per cycle and steps the generator only on a
// grant or during warm-up, so the stream is reproducible for a given seed and
// grant order.
module rand_dispenser #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned WARMUP    = 8,
    parameter logic [63:0] SEED_0    = 64'd1,
    parameter logic [63:0] SEED_1    = 64'd2
) (
    input  logic                 clock,
    input  logic                 n_rst,
    input  logic                 seed_load,
    input  logic [63:0]          seed_0,
    input  logic [63:0]          seed_1,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   ack,
    output logic [OUT_WIDTH-1:0] rand_out,
    output logic                 busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t               state;
    logic [63:0]          s0;
    logic [63:0]          s1;
    logic [CNT_W-1:0]     warm_cnt;
    logic [IDX_W-1:0]     last_grant;

    logic [63:0]          gen_value;
    logic [63:0]          gen_t;
    logic [63:0]          gen_s1_next;
    logic [OUT_WIDTH-1:0] rand_next;
    logic [63:0]          load_s0;
    logic [63:0]          load_s1;
    logic [NUM_REQ-1:0]   eligible;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;

    // XorShift128+ step: output value and next state_1 (state_0 takes old state_1)
    always_comb begin
        gen_value   = s0 + s1;
        gen_t       = s0 ^ (s0 << 23);
        gen_s1_next = gen_t ^ (gen_t >> 17) ^ s1 ^ (s1 >> 26);
        rand_next   = OUT_WIDTH'(gen_value >> (64 - OUT_WIDTH));
    end

    // Seed substitution: an all-zero seed would lock the generator at zero
    always_comb begin
        load_s0 = seed_0;
        load_s1 = seed_1;
        if ((seed_0 | seed_1) == 64'd0) begin
            load_s0 = SEED_0;
            load_s1 = SEED_1;
        end
    end

    // Round-robin pick: first eligible index after last_grant, wrapping
    always_comb begin
        eligible  = req & ~ack;
        win_found = 1'b0;
        win_idx   = last_grant;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'((32'(last_grant) + i) % NUM_REQ);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Control FSM, generator state and registered outputs
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_INIT;
            s0         <= SEED_0;
            s1         <= SEED_1;
            warm_cnt   <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            ack        <= '0;
            rand_out   <= '0;
            busy       <= 1'b1;
        end else if (seed_load) begin
            state    <= ST_INIT;
            s0       <= load_s0;
            s1       <= load_s1;
            warm_cnt <= '0;
            ack      <= '0;
            busy     <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    ack <= '0;
                    if (warm_cnt == CNT_W'(WARMUP)) begin
                        state <= ST_SERVE;
                        busy  <= 1'b0;
                    end else begin
                        s0       <= s1;
                        s1       <= gen_s1_next;
                        warm_cnt <= warm_cnt + CNT_W'(1);
                    end
                end
                ST_SERVE: begin
                    ack <= '0;
                    if (win_found) begin
                        ack[win_idx] <= 1'b1;
                        rand_out     <= rand_next;
                        s0           <= s1;
                        s1           <= gen_s1_next;
                        last_grant   <= win_idx;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rand_dispenser.sv
// Testbench for rand_dispenser: warm-up, single-requester cadence,
// round-robin order, mid-run seed load, zero seed and async reset.
module tb_rand_dispenser;

    logic        clock;
    logic        n_rst;
    logic        seed_load;
    logic [63:0] seed_0;
    logic [63:0] seed_1;

    logic [3:0]  req_a;
    logic [3:0]  ack_a;
    logic [63:0] rand_a;
    logic        busy_a;

    logic [1:0]  req_b;
    logic [1:0]  ack_b;
    logic [31:0] rand_b;
    logic        busy_b;
    logic        seed_load_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] ms0;
    logic [63:0] ms1;
    logic [63:0] last_rand;
    logic [63:0] v;

    typedef struct {
        logic [3:0] req;
        logic [3:0] ack;
        logic       busy;
    } vec_t;

    vec_t vecs[13];

    rand_dispenser #(
        .NUM_REQ(4), .OUT_WIDTH(64), .WARMUP(0),
        .SEED_0(64'd1), .SEED_1(64'd2)
    ) dut_a (
        .clock(clock), .n_rst(n_rst), .seed_load(seed_load),
        .seed_0(seed_0), .seed_1(seed_1), .req(req_a),
        .ack(ack_a), .rand_out(rand_a), .busy(busy_a)
    );

    rand_dispenser #(
        .NUM_REQ(2), .OUT_WIDTH(32), .WARMUP(8),
        .SEED_0(64'd1), .SEED_1(64'd2)
    ) dut_b (
        .clock(clock), .n_rst(n_rst), .seed_load(seed_load_b),
        .seed_0(seed_0), .seed_1(seed_1), .req(req_b),
        .ack(ack_b), .rand_out(rand_b), .busy(busy_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset;
        ms0 = 64'd1;
        ms1 = 64'd2;
    endtask

    task automatic model_step(output logic [63:0] val);
        logic [63:0] t;
        logic [63:0] n1;
        val = ms0 + ms1;
        t   = ms0 ^ (ms0 << 23);
        n1  = t ^ (t >> 17) ^ ms1 ^ (ms1 >> 26);
        ms0 = ms1;
        ms1 = n1;
    endtask

    initial begin
        vecs[0]  = '{4'b1111, 4'b0000, 1'b0};
        vecs[1]  = '{4'b1111, 4'b0001, 1'b0};
        vecs[2]  = '{4'b1111, 4'b0010, 1'b0};
        vecs[3]  = '{4'b1111, 4'b0100, 1'b0};
        vecs[4]  = '{4'b1111, 4'b1000, 1'b0};
        vecs[5]  = '{4'b1111, 4'b0001, 1'b0};
        vecs[6]  = '{4'b1101, 4'b0100, 1'b0};
        vecs[7]  = '{4'b1101, 4'b1000, 1'b0};
        vecs[8]  = '{4'b1101, 4'b0001, 1'b0};
        vecs[9]  = '{4'b1101, 4'b0100, 1'b0};
        vecs[10] = '{4'b0000, 4'b0000, 1'b0};
        vecs[11] = '{4'b0000, 4'b0000, 1'b0};
        vecs[12] = '{4'b0001, 4'b0001, 1'b0};

        n_rst       = 1'b0;
        seed_load   = 1'b0;
        seed_load_b = 1'b0;
        seed_0      = 64'd0;
        seed_1      = 64'd0;
        req_a       = 4'b0000;
        req_b       = 2'b00;

        // Reset state
        tick;
        tick;
        check("rst_ack_a",  64'(ack_a),  64'd0);
        check("rst_rand_a", rand_a,      64'd0);
        check("rst_busy_a", 64'(busy_a), 64'd1);
        check("rst_ack_b",  64'(ack_b),  64'd0);
        check("rst_busy_b", 64'(busy_b), 64'd1);

        // Warm-up of 8 steps with a requester held from reset
        req_b = 2'b01;
        n_rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            check($sformatf("warm_busy_%0d", k), 64'(busy_b), 64'd1);
        end
        tick;
        check("warm_busy_done", 64'(busy_b), 64'd0);
        check("warm_no_ack",    64'(ack_b),  64'd0);
        tick;
        model_reset();
        for (int k = 0; k < 8; k++) model_step(v);
        model_step(v);
        check("warm_ack",  64'(ack_b),  64'd1);
        check("warm_rand", 64'(rand_b), 64'(v[63:32]));
        req_b = 2'b00;

        // Single requester held: one grant every other cycle
        n_rst = 1'b0;
        tick;
        req_a = 4'b0001;
        n_rst = 1'b1;
        tick;
        check("single_busy_low", 64'(busy_a), 64'd0);
        check("single_ack_e1",   64'(ack_a),  64'd0);
        tick;
        check("single_ack_e2",   64'(ack_a),  64'd1);
        check("single_rand_1",   rand_a,      64'h3);
        tick;
        check("single_ack_e3",   64'(ack_a),  64'd0);
        tick;
        check("single_ack_e4",   64'(ack_a),  64'd1);
        check("single_rand_2",   rand_a,      64'h800045);

        // Round-robin table with all requesters, then one dropped, then idle
        n_rst = 1'b0;
        tick;
        req_a = 4'b1111;
        n_rst = 1'b1;
        model_reset();
        last_rand = 64'd0;
        for (int i = 0; i < 13; i++) begin
            req_a = vecs[i].req;
            tick;
            check($sformatf("rr_ack_%0d", i),  64'(ack_a),  64'(vecs[i].ack));
            check($sformatf("rr_busy_%0d", i), 64'(busy_a), 64'(vecs[i].busy));
            if (vecs[i].ack != 4'b0000) begin
                model_step(v);
                last_rand = v;
            end
            check($sformatf("rr_rand_%0d", i), rand_a, last_rand);
        end

        // Seed load beats a pending request; stream restarts, request kept
        req_a     = 4'b0010;
        seed_load = 1'b1;
        seed_0    = 64'd1;
        seed_1    = 64'd2;
        tick;
        seed_load = 1'b0;
        check("sl_no_ack", 64'(ack_a),  64'd0);
        check("sl_busy",   64'(busy_a), 64'd1);
        tick;
        check("sl_busy_low", 64'(busy_a), 64'd0);
        check("sl_ack_init", 64'(ack_a),  64'd0);
        tick;
        check("sl_ack_1",  64'(ack_a), 64'b0010);
        check("sl_rand_1", rand_a,     64'h3);
        tick;
        check("sl_ack_gap", 64'(ack_a), 64'd0);
        tick;
        check("sl_ack_2",  64'(ack_a), 64'b0010);
        check("sl_rand_2", rand_a,     64'h800045);

        // Zero seed falls back to the default seeds
        req_a     = 4'b0001;
        seed_load = 1'b1;
        seed_0    = 64'd0;
        seed_1    = 64'd0;
        tick;
        seed_load = 1'b0;
        check("zs_no_ack", 64'(ack_a),  64'd0);
        check("zs_busy",   64'(busy_a), 64'd1);
        tick;
        check("zs_busy_low", 64'(busy_a), 64'd0);
        tick;
        check("zs_ack_1",  64'(ack_a), 64'd1);
        check("zs_rand_1", rand_a,     64'h3);
        tick;
        check("zs_ack_gap", 64'(ack_a), 64'd0);
        tick;
        check("zs_ack_2",  64'(ack_a), 64'd1);
        check("zs_rand_2", rand_a,     64'h800045);
        check("zs_rand_nonzero", 64'(rand_a != 64'd0), 64'd1);

        // Asynchronous reset between edges while ack is high
        #2;
        n_rst = 1'b0;
        #1;
        check("ar_ack",  64'(ack_a),  64'd0);
        check("ar_rand", rand_a,      64'd0);
        check("ar_busy", 64'(busy_a), 64'd1);
        tick;
        n_rst = 1'b1;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
